// File: rtl/booth_mult4.sv
// Sequential radix-2 Booth multiplier: signed N x N -> 2N product, one
// Booth step per clock while busy, single-cycle done pulse when complete.
module booth_mult4 #(
    parameter int N = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    output logic             busy,
    output logic             done,
    output logic [2*N-1:0]   product
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;

    logic [N:0]     a_reg;
    logic [N:0]     m_reg;
    logic [N-1:0]   q_reg;
    logic           q_1;
    logic [CW-1:0]  count;

    logic [1:0]     booth_sel;
    logic           sub;
    logic           add_en;
    logic [N:0]     addend;
    logic [N:0]     sum;
    logic [N:0]     a_sh;
    logic [N-1:0]   q_sh;
    logic           last;

    // Subtraction reuses the adder: inverted M with the mode bit as carry-in.
    always_comb begin
        booth_sel = {q_reg[0], q_1};
        sub       = (booth_sel == 2'b10);
        add_en    = booth_sel[1] ^ booth_sel[0];
        addend    = sub ? ~m_reg : m_reg;
        sum       = add_en ? (a_reg + addend + (N+1)'(sub)) : a_reg;
        a_sh      = {sum[N], sum[N:1]};
        q_sh      = {sum[0], q_reg[N-1:1]};
        last      = (count == CW'(1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg   <= '0;
            m_reg   <= '0;
            q_reg   <= '0;
            q_1     <= 1'b0;
            count   <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= '0;
                        m_reg <= {a[N-1], a};
                        q_reg <= b;
                        q_1   <= 1'b0;
                        count <= CW'(N);
                    end
                end
                CALC: begin
                    a_reg <= a_sh;
                    q_reg <= q_sh;
                    q_1   <= q_reg[0];
                    count <= count - CW'(1);
                    if (last) begin
                        product <= {a_sh[N-1:0], q_sh};
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mult4.sv
// Directed bench for booth_mult4 (N=4): reset, signed corner products,
// operand/start isolation, mid-operation reset and an exhaustive back-to-back sweep.
module tb_booth_mult4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] a = '0;
    logic [3:0] b = '0;
    logic       busy;
    logic       done;
    logic [7:0] product;

    int n_cmp = 0;
    int n_err = 0;
    int edge_cnt = 0;

    booth_mult4 #(.N(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt++;

    // Waits on negedges (start dropped after the first) until done, bounded.
    task automatic wait_done(output int cycles, output bit ok);
        cycles = 0;
        ok = 1'b0;
        while (cycles < 20) begin
            @(negedge clk);
            start = 1'b0;
            cycles++;
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++;
        if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++;
        if (product !== 8'h00) begin n_err++; $display("FAIL reset_product: got %h want 00", product); end
        rst = 1'b0;
    endtask

    task automatic test_basic;
        int cyc;
        int busy_cnt;
        bit ok;
        @(negedge clk);
        a = 4'd3; b = 4'd5; start = 1'b1;
        cyc = 0; busy_cnt = 0; ok = 1'b0;
        while (cyc < 20) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin ok = 1'b1; break; end
        end
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL basic_timeout: no done within %0d cycles", cyc); end
        n_cmp++;
        if (cyc != 5) begin n_err++; $display("FAIL basic_latency: got %0d want 5", cyc); end
        n_cmp++;
        if (busy_cnt != 4) begin n_err++; $display("FAIL basic_busy_cycles: got %0d want 4", busy_cnt); end
        n_cmp++;
        if (product !== 8'h0F) begin n_err++; $display("FAIL basic_product: got %h want 0f", product); end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0) begin n_err++; $display("FAIL basic_done_width: got %b want 0", done); end
    endtask

    task automatic test_signed;
        logic [3:0] va [5] = '{4'h8, 4'h8, 4'hF, 4'h0, 4'h7};
        logic [3:0] vb [5] = '{4'h8, 4'h7, 4'hF, 4'hB, 4'h7};
        logic [7:0] vp [5] = '{8'h40, 8'hC8, 8'h01, 8'h00, 8'h31};
        int cyc;
        bit ok;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a = va[i]; b = vb[i]; start = 1'b1;
            wait_done(cyc, ok);
            n_cmp++;
            if (!ok) begin n_err++; $display("FAIL signed_timeout[%0d]: no done", i); end
            n_cmp++;
            if (product !== vp[i])
                begin n_err++; $display("FAIL signed_product[%0d]: a=%h b=%h got %h want %h", i, va[i], vb[i], product, vp[i]); end
        end
    endtask

    task automatic test_hold;
        int cyc;
        int pulses;
        bit ok;
        bit stable;
        @(negedge clk);
        a = 4'h9; b = 4'h6; start = 1'b1;
        cyc = 0; ok = 1'b0;
        while (cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (done === 1'b1) begin ok = 1'b1; break; end
            a = 4'($urandom); b = 4'($urandom);
        end
        start = 1'b0;
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL hold_timeout: no done"); end
        n_cmp++;
        if (cyc != 5) begin n_err++; $display("FAIL hold_latency: got %0d want 5", cyc); end
        n_cmp++;
        if (product !== 8'hD6) begin n_err++; $display("FAIL hold_product: got %h want d6", product); end
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        n_cmp++;
        if (pulses != 0) begin n_err++; $display("FAIL hold_extra_done: got %0d pulses want 0", pulses); end
        a = 4'h1; b = 4'h1; start = 1'b1;
        stable = 1'b1;
        cyc = 0; ok = 1'b0;
        while (cyc < 20) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (done === 1'b1) begin ok = 1'b1; break; end
            if (product !== 8'hD6) stable = 1'b0;
        end
        n_cmp++;
        if (!stable) begin n_err++; $display("FAIL hold_product_stable: got %h want d6", product); end
        n_cmp++;
        if (!ok || product !== 8'h01) begin n_err++; $display("FAIL hold_second_product: got %h want 01", product); end
    endtask

    task automatic test_reset_mid;
        int cyc;
        int pulses;
        bit ok;
        @(negedge clk);
        a = 4'h5; b = 4'h3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        n_cmp++;
        if (done !== 1'b0) begin n_err++; $display("FAIL rstmid_done: got %b want 0", done); end
        n_cmp++;
        if (product !== 8'h00) begin n_err++; $display("FAIL rstmid_product: got %h want 00", product); end
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        n_cmp++;
        if (pulses != 0) begin n_err++; $display("FAIL rstmid_done_pulse: got %0d want 0", pulses); end
        rst = 1'b0; a = 4'h2; b = 4'hD; start = 1'b1;
        wait_done(cyc, ok);
        n_cmp++;
        if (!ok || cyc != 5) begin n_err++; $display("FAIL rstmid_restart_latency: got %0d want 5", cyc); end
        n_cmp++;
        if (product !== 8'hFA) begin n_err++; $display("FAIL rstmid_product_after: got %h want fa", product); end
    endtask

    task automatic test_back_to_back;
        logic signed [3:0] sa;
        logic signed [3:0] sb;
        logic signed [7:0] exp_p;
        logic [7:0]        idx;
        int prev_edge;
        int cyc;
        bit ok;
        prev_edge = -1;
        @(negedge clk);
        for (int i = 0; i < 256; i++) begin
            idx = 8'(i);
            sa = idx[7:4];
            sb = idx[3:0];
            exp_p = sa * sb;
            a = idx[7:4]; b = idx[3:0]; start = 1'b1;
            cyc = 0; ok = 1'b0;
            while (cyc < 20) begin
                @(negedge clk);
                cyc++;
                if (done === 1'b1) begin ok = 1'b1; break; end
                a = 4'($urandom); b = 4'($urandom);
            end
            n_cmp++;
            if (!ok || product !== exp_p)
                begin n_err++; $display("FAIL sweep_product: a=%0d b=%0d got %h want %h", sa, sb, product, exp_p); end
            if (prev_edge >= 0) begin
                n_cmp++;
                if (edge_cnt - prev_edge != 6)
                    begin n_err++; $display("FAIL sweep_spacing: a=%0d b=%0d got %0d edges want 6", sa, sb, edge_cnt - prev_edge); end
            end
            prev_edge = edge_cnt;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_signed;
        test_hold;
        test_reset_mid;
        test_back_to_back;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/booth_mult4.md
BOOTH_MULT4 -- requirements
Module: booth_mult4

Interface
REQ-001 SHALL have parameter N, default 4, giving the operand width in bits; the product width is 2N.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: request to begin a multiplication.
REQ-005 SHALL have port a, input, N bits: multiplicand, signed two's complement.
REQ-006 SHALL have port b, input, N bits: multiplier, signed two's complement.
REQ-007 SHALL have port busy, output, 1 bit: high while an iteration is in progress.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse when product is valid.
REQ-009 SHALL have port product, output, 2N bits: signed product a*b, registered.

Function
REQ-010 SHALL implement radix-2 Booth multiplication as an FSM with the states IDLE, CALC and DONE.
REQ-011 SHALL hold these internal registers: A (N+1 bits), M (N+1 bits, a sign-extended), Q (N bits), q_1 (1 bit), and count (enough bits to hold N).
REQ-012 SHALL, in IDLE with start=1 at a rising edge, load M=sext(a), Q=b, A=0, q_1=0 and count=N, then enter CALC.
REQ-013 SHALL ignore start in CALC and DONE, with no reload and no effect on the operation in progress.
REQ-014 SHALL ignore a and b at every edge except the load edge; operands may change freely while busy=1.
REQ-015 SHALL perform one iteration per CALC edge, selected by {Q[0],q_1}:
- 01: A+M.
- 10: A-M.
- 00 or 11: A unchanged.
REQ-016 SHALL form subtraction as A + (M XOR all-ones) + 1, i.e. the mode bit inverts the operand and serves as carry-in, computed with N+1-bit wrap-around.
REQ-017 SHALL, in the same CALC edge as REQ-015, arithmetic-shift {A_new,Q,q_1} right by one, replicate A_new[N], and decrement count.
REQ-018 SHALL, on the CALC edge where count reaches 0, register product = {A_new_shifted[N-1:0], Q_shifted} and enter DONE.
REQ-019 SHALL assert done=1 for exactly the one cycle spent in DONE, then return to IDLE unconditionally at the next edge.
REQ-020 SHALL set busy=1 exactly while in CALC.
REQ-021 SHALL have a latency of N+1 edges from the start-sampling edge to done asserting; that edge is exactly N CALC edges after the load edge.
REQ-022 SHALL hold product stable from the DONE entry until the next DONE entry; loading new operands SHALL NOT alter product.
REQ-023 SHALL accept a start asserted in the same cycle that DONE returns to IDLE at the next edge, giving a minimum of N+2 edges per operation.
REQ-024 SHALL produce correct results for all 2^(2N) operand pairs, including the most negative operand on both inputs, with no overflow.

Reset
REQ-025 SHALL, while rst=1, immediately and regardless of clk, force:
- state=IDLE;
- busy=0, done=0;
- product=0;
- A, M, Q, q_1 and count all 0.
REQ-026 SHALL abandon any in-progress operation on reset mid-CALC or mid-DONE, with no done pulse and product left at 0.
REQ-027 SHALL accept start at the first rising edge after rst deasserts.

Verification
REQ-028 SHALL pass this scenario: a=3, b=5, start pulse -> busy high for 4 cycles, done high 5 edges after start, product=0x0F.
REQ-029 SHALL pass this scenario: a=-8 (1000), b=-8 -> product=0x40 (+64); a=-8, b=7 -> product=0xC8 (-56); a=-1, b=-1 -> product=0x01.
REQ-030 SHALL pass this scenario: a=0, b=-5 -> product=0x00; a=7, b=7 -> product=0x31 (+49).
REQ-031 SHALL pass this scenario: start held high and a, b changed every cycle during CALC -> result equals the load-edge operands and only one done pulse occurs per operation.
REQ-032 SHALL pass this scenario: rst pulsed at the 2nd CALC cycle -> busy, done and product are 0 immediately; a later start with a=2, b=-3 -> product=0xFA (-6).
REQ-033 SHALL pass this scenario: exhaustive sweep of all 256 pairs with back-to-back starts -> every product equals the signed reference product, and done pulses are spaced N+2 edges apart.
